// File: rtl/tt_serial_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding,
// pin-map bit positions for ui_in/uo_out, and the bit-counter width.
// Ports: none (package only).
package tt_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // ui_in bit positions
    localparam int UI_A     = 0;
    localparam int UI_B     = 1;
    localparam int UI_VLD   = 2;
    localparam int UI_START = 3;

    // uo_out bit positions
    localparam int UO_SUM   = 0;
    localparam int UO_SVLD  = 1;
    localparam int UO_COUT  = 2;
    localparam int UO_DONE  = 3;
    localparam int UO_BUSY  = 4;

    // Counter is sized for the largest legal operand width.
    localparam int CNT_W = $clog2(8);

endpackage

// File: rtl/tt_ha_cell.sv
// Combinational half adder cell; two of these plus an OR make a full adder.
// Latency: zero (pure combinational). Backpressure: none.
// Ports: a_i, b_i operand bits; sum_o = a^b; carry_o = a&b.
module tt_ha_cell (
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic carry_o
);

    assign sum_o   = a_i ^ b_i;
    assign carry_o = a_i & b_i;

endmodule

// File: rtl/tt_um_serial_adder.sv
// Bit-serial adder, LSB first, with registered carry and parallel sum output.
// Latency: each accepted bit pair yields its sum bit one cycle later; done one cycle after the last pair.
// Backpressure: none; in_valid may gap for any number of cycles, ena low freezes all state.
// Ports: clk, rst_n (async active-low), ena; ui_in[0]=a, [1]=b, [2]=in_valid, [3]=start;
//        uo_out[0]=sum_bit, [1]=sum_valid, [2]=carry_out, [3]=done, [4]=busy;
//        uio_out = assembled sum (zero-extended), uio_oe = all ones, uio_in unused.
module tt_um_serial_adder
    import tt_serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               sum_bit_q, sum_bit_d;
    logic               sum_vld_q, sum_vld_d;
    logic               carry_out_q, carry_out_d;
    logic               done_q, done_d;

    logic a_bit, b_bit, in_vld, start;
    logic ha0_sum, ha0_carry, ha1_sum, ha1_carry;
    logic carry_next;
    logic unused_inputs;

    assign a_bit  = ui_in[UI_A];
    assign b_bit  = ui_in[UI_B];
    assign in_vld = ui_in[UI_VLD];
    assign start  = ui_in[UI_START];

    assign unused_inputs = &{1'b0, ui_in[7:4], uio_in};

    // Full adder: first cell adds the operands, second folds in the carry.
    tt_ha_cell u_ha0 (
        .a_i     (a_bit),
        .b_i     (b_bit),
        .sum_o   (ha0_sum),
        .carry_o (ha0_carry)
    );

    tt_ha_cell u_ha1 (
        .a_i     (ha0_sum),
        .b_i     (carry_q),
        .sum_o   (ha1_sum),
        .carry_o (ha1_carry)
    );

    assign carry_next = ha0_carry | ha1_carry;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        sum_d       = sum_q;
        sum_bit_d   = sum_bit_q;
        sum_vld_d   = 1'b0;          // sum_valid is a single-cycle pulse
        carry_out_d = carry_out_q;
        done_d      = done_q;

        if (start) begin
            // start wins over in_valid: the coincident bit pair is dropped.
            state_d     = RUN;
            cnt_d       = '0;
            carry_d     = 1'b0;
            sum_d       = '0;
            carry_out_d = 1'b0;
            done_d      = 1'b0;
        end else if (state_q == RUN && in_vld) begin
            sum_bit_d = ha1_sum;
            sum_vld_d = 1'b1;
            carry_d   = carry_next;
            for (int i = 0; i < WIDTH; i++) begin
                if (cnt_q == CNT_W'(i)) begin
                    sum_d[i] = ha1_sum;
                end
            end
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                state_d     = DONE;
                cnt_d       = '0;
                done_d      = 1'b1;
                carry_out_d = carry_next;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (state_q != IDLE && state_q != RUN && state_q != DONE) begin
            // Unused encoding recovers to IDLE.
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            sum_bit_q   <= 1'b0;
            sum_vld_q   <= 1'b0;
            carry_out_q <= 1'b0;
            done_q      <= 1'b0;
        end else if (ena) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            sum_q       <= sum_d;
            sum_bit_q   <= sum_bit_d;
            sum_vld_q   <= sum_vld_d;
            carry_out_q <= carry_out_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        uo_out          = '0;
        uo_out[UO_SUM]  = sum_bit_q;
        uo_out[UO_SVLD] = sum_vld_q;
        uo_out[UO_COUT] = carry_out_q;
        uo_out[UO_DONE] = done_q;
        uo_out[UO_BUSY] = (state_q == RUN);
    end

    always_comb begin
        uio_out             = '0;
        uio_out[WIDTH-1:0]  = sum_q;
    end

    assign uio_oe = 8'hFF;

endmodule
